// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit adder/subtractor with the carry chain split over STAGES registered chunks.
// Valid/ready stream with a single global advance enable and backpressure.
module pipelined_adder_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad
    $error("WIDTH must be a non-zero multiple of STAGES");
  end

  localparam int CW = WIDTH / (STAGES < 1 ? 1 : STAGES);
  localparam logic [WIDTH-1:0] MSK = WIDTH'({CW{1'b1}});

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             o_q;

  logic             av [STAGES];
  logic [WIDTH-1:0] aa [STAGES];
  logic [WIDTH-1:0] ab [STAGES];
  logic [WIDTH-1:0] si [STAGES];
  logic             ac [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic             nc [STAGES];
  logic             cm;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~c_in : c_in;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    logic [CW:0]      t;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] ch;

    if (k == 0) begin : g_in
      assign av[k] = in_valid;
      assign aa[k] = a;
      assign ab[k] = b_eff;
      assign si[k] = '0;
      assign ac[k] = cin_eff;
    end else begin : g_fwd
      assign av[k] = v_q[k-1];
      assign aa[k] = a_q[k-1];
      assign ab[k] = b_q[k-1];
      assign si[k] = s_q[k-1];
      assign ac[k] = c_q[k-1];
    end

    assign t = {1'b0, aa[k][k*CW +: CW]}
             + {1'b0, ab[k][k*CW +: CW]}
             + {{CW{1'b0}}, ac[k]};
    assign m  = MSK << (k * CW);
    assign ch = WIDTH'(t[CW-1:0]) << (k * CW);
    // merge this chunk's sum into the de-skewed lower result
    assign ns[k] = (si[k] & ~m) | ch;
    assign nc[k] = t[CW];
  end

  // carry into the MSB recovered from the MSB sum bit
  assign cm = aa[STAGES-1][WIDTH-1]
            ^ ab[STAGES-1][WIDTH-1]
            ^ ns[STAGES-1][WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
        c_q[i] <= 1'b0;
      end
      o_q <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= av[i];
        a_q[i] <= aa[i];
        b_q[i] <= ab[i];
        s_q[i] <= ns[i];
        c_q[i] <= nc[i];
      end
      o_q <= cm ^ nc[STAGES-1];
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = o_q;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: three instances (STAGES 4, 1, 16) on shared
// operands, one selected at a time through in_valid gating and an output mux.
module tb_pipelined_adder_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        c_in;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  int          sel;

  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [15:0] sm [3];

  logic        dv;
  logic        dr;
  logic        dc;
  logic        dof;
  logic [15:0] ds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iv = {in_valid && sel == 2, in_valid && sel == 1, in_valid && sel == 0};

  always_comb begin
    dv  = ov[sel];
    dr  = ir[sel];
    dc  = co[sel];
    dof = of[sel];
    ds  = sm[sel];
  end

  pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sm[0]), .c_out(co[0]), .ovf(of[0])
  );

  pipelined_adder_sub #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sm[1]), .c_out(co[1]), .ovf(of[1])
  );

  pipelined_adder_sub #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sm[2]), .c_out(co[2]), .ovf(of[2])
  );

  function automatic int lat(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 16;
  endfunction

  // golden result {c_out, ovf, sum}; overflow from operand/result signs
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] ye;
    logic        ce;
    logic [16:0] r;
    logic        o;
    ye = sb ? ~y : y;
    ce = sb ? ~ci : ci;
    r  = {1'b0, x} + {1'b0, ye} + {16'h0, ce};
    o  = (x[15] == ye[15]) && (r[15] != x[15]);
    return {r[16], o, r[15:0]};
  endfunction

  task automatic drive_rand();
    a    = 16'($urandom);
    b    = 16'($urandom);
    c_in = 1'($urandom_range(0, 1));
    sub  = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || sm[i] !== 16'h0 || co[i] !== 1'b0 || of[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: valid=%b sum=%h c=%b ovf=%b, want 0 0000 0 0",
                 i, ov[i], sm[i], co[i], of[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset inst%0d: in_ready=%b, want 1", i, ir[i]);
      end
    end
  endtask

  task automatic test_basic(input int s);
    logic [15:0] ta [8] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000,
                            16'h1234, 16'h0010, 16'h8000, 16'h0003};
    logic [15:0] tb [8] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001,
                            16'h4321, 16'h0003, 16'h8000, 16'h0003};
    logic        tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        ts [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] te [8] = '{{2'b10, 16'h0000}, {2'b01, 16'h8000},
                            {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF},
                            {2'b00, 16'h5556}, {2'b10, 16'h000C},
                            {2'b11, 16'h0000}, {2'b10, 16'h0000}};
    int n;
    sel = s;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = ta[i]; b = tb[i]; c_in = tc[i]; sub = ts[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (!dv && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++;
      if (n !== lat(s)) begin
        errors++;
        $display("FAIL latency s%0d v%0d: %0d edges, want %0d", lat(s), i, n, lat(s));
      end
      checks++;
      if ({dc, dof, ds} !== te[i]) begin
        errors++;
        $display("FAIL basic s%0d v%0d: c=%b ovf=%b sum=%h, want c=%b ovf=%b sum=%h",
                 lat(s), i, dc, dof, ds, te[i][17], te[i][16], te[i][15:0]);
      end
    end
  endtask

  task automatic test_back_to_back(input int s);
    logic [17:0] q[$];
    logic [17:0] e;
    logic        acc;
    int sent = 0, got = 0, first = -1, last = -1, cyc = 0;
    sel = s;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drive_rand();
    in_valid = 1'b1;
    while (got < 100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (dv && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious s%0d: result %h with nothing pending", lat(s), ds);
        end else begin
          e = q.pop_front();
          if ({dc, dof, ds} !== e) begin
            errors++;
            $display("FAIL b2b s%0d #%0d: got %h, want %h", lat(s), got, {dc, dof, ds}, e);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      acc = in_valid && dr;
      if (acc) begin
        q.push_back(model(a, b, c_in, sub));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (sent < 100) drive_rand();
        else in_valid = 1'b0;
      end
    end
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL b2b_count s%0d: %0d results, want 100", lat(s), got);
    end
    checks++;
    if (last - first != 99) begin
      errors++;
      $display("FAIL b2b_rate s%0d: span %0d cycles, want 99", lat(s), last - first);
    end
  endtask

  task automatic test_backpressure(input int s);
    logic [17:0] q[$];
    logic [17:0] e;
    logic [17:0] held;
    logic        acc;
    int sent = 0, got = 0, stall = 0, cyc = 0;
    sel = s;
    out_ready = 1'b0;
    held = '0;
    @(posedge clk);
    #1;
    drive_rand();
    in_valid = 1'b1;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dv && !out_ready) begin
        checks++;
        if (stall == 0) begin
          held = {dc, dof, ds};
          if (dr !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready s%0d: in_ready=%b, want 0", lat(s), dr);
          end
        end else if (dr !== 1'b0 || {dc, dof, ds} !== held) begin
          errors++;
          $display("FAIL bp_hold s%0d: in_ready=%b out=%h, want 0 %h",
                   lat(s), dr, {dc, dof, ds}, held);
        end
        stall++;
      end
      if (dv && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_spurious s%0d: result %h with nothing pending", lat(s), ds);
        end else begin
          e = q.pop_front();
          if ({dc, dof, ds} !== e) begin
            errors++;
            $display("FAIL bp s%0d #%0d: got %h, want %h", lat(s), got, {dc, dof, ds}, e);
          end
        end
        got++;
      end
      acc = in_valid && dr;
      if (acc) begin
        q.push_back(model(a, b, c_in, sub));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (sent < 8) drive_rand();
        else in_valid = 1'b0;
      end
      if (stall >= 5) out_ready = 1'b1;
    end
    checks++;
    if (got != 8 || stall != 5) begin
      errors++;
      $display("FAIL bp_count s%0d: %0d results %0d stalls, want 8 and 5", lat(s), got, stall);
    end
  endtask

  task automatic test_midstream_reset(input int s);
    int n = 0;
    int seen = 0;
    sel = s;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    while (!dv && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (dv !== 1'b1 || {dc, dof, ds} !== {2'b00, 16'h2345}) begin
      errors++;
      $display("FAIL pre_reset s%0d: valid=%b out=%h, want 1 %h",
               lat(s), dv, {dc, dof, ds}, {2'b00, 16'h2345});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dv !== 1'b0 || ds !== 16'h0 || dc !== 1'b0 || dof !== 1'b0) begin
      errors++;
      $display("FAIL async_reset s%0d: valid=%b sum=%h c=%b ovf=%b, want all 0",
               lat(s), dv, ds, dc, dof);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (dr !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready s%0d: in_ready=%b, want 1", lat(s), dr);
    end
    repeat (25) begin
      @(negedge clk);
      if (dv) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stale_result s%0d: %0d valid cycles after reset, want 0", lat(s), seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    c_in = 1'b0;
    sub = 1'b0;
    sel = 0;
    test_reset();
    for (int s = 0; s < 3; s++) begin
      test_basic(s);
      test_back_to_back(s);
      test_backpressure(s);
    end
    test_midstream_reset(0);
    test_midstream_reset(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
